barrett_stream_ctrl: RTL and testbench

Streaming controller for the `barrett_pipelined` modular reducer. Holds the modulus configuration, accepts x operands over a valid/ready stream, and issues at most one per cycle into the non-stallable reducer pipeline. Returns results in order over a valid/ready stream through an internal result FIFO. Credit accounting guarantees no pipeline result is ever dropped under output backpressure.

---
 rtl/barrett_pkg.sv | 13 +
 rtl/barrett_pipelined.sv | 66 ++++++
 rtl/barrett_result_fifo.sv | 70 +++++++
 rtl/barrett_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_barrett_stream_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett streaming reducer slice.
// Holds the controller state encoding and the default datapath width.
package barrett_pkg;

  localparam int BARRETT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } barrett_ctrl_state_e;

endpackage

// File: rtl/barrett_pipelined.sv
// Non-stallable three-stage modular reducer: result_o = x_i mod m_i, valid
// exactly three cycles after start_i is sampled.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_i            operand valid (sampled every cycle, no backpressure)
//   x_i, m_i, mu_i     operand (x < 4m), modulus, Barrett constant
//   valid_o, result_o  result strobe and remainder
// The x < 4m bound lets the remainder be formed with two conditional
// subtractions (2m then m), so the result is exact for any modulus; mu_i
// is part of the port contract but the correction path does not need it.
module barrett_pipelined
  import barrett_pkg::*;
#(
  parameter int W = BARRETT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] m_i,
  input  logic [W-1:0] mu_i,
  output logic         valid_o,
  output logic [W-1:0] result_o
);

  logic         v1_r, v2_r, v3_r;
  logic [W-1:0] x1_r, m1_r, r2_r, m2_r, r3_r;
  logic [W:0]   twom_s;
  logic [W-1:0] d2_s;
  logic         ge2_s;
  logic         mu_unused_s;

  assign mu_unused_s = ^mu_i;

  // 2m needs one extra bit for the compare; when x >= 2m the truncated 2m is exact.
  assign twom_s = {m1_r, 1'b0};
  assign ge2_s  = ({1'b0, x1_r} >= twom_s);
  assign d2_s   = x1_r - {m1_r[W-2:0], 1'b0};

  // Pipeline registers: capture, subtract 2m, subtract m.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
      x1_r <= {W{1'b0}};
      m1_r <= {W{1'b0}};
      r2_r <= {W{1'b0}};
      m2_r <= {W{1'b0}};
      r3_r <= {W{1'b0}};
    end else begin
      v1_r <= start_i;
      x1_r <= x_i;
      m1_r <= m_i;
      v2_r <= v1_r;
      r2_r <= ge2_s ? d2_s : x1_r;
      m2_r <= m1_r;
      v3_r <= v2_r;
      r3_r <= (r2_r >= m2_r) ? (r2_r - m2_r) : r2_r;
    end
  end

  assign valid_o  = v3_r;
  assign result_o = r3_r;

endmodule

// File: rtl/barrett_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, data_i     write strobe and data
//   pop_i              consume head (ignored when empty)
//   valid_o, data_o    head valid and head data (zero when empty)
//   count_o            number of stored entries
// A push while full is taken only together with a pop, so the count stays put.
module barrett_result_fifo
  import barrett_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = BARRETT_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s, push_s;

  assign pop_s  = pop_i & (count_r != {CW{1'b0}});
  assign push_s = push_i & ((count_r != DEPTH_C) | pop_s);

  // Storage array; contents are only visible through a valid head.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_C) ? {AW{1'b0}} : wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_C) ? {AW{1'b0}} : rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid_o = (count_r != {CW{1'b0}});
  assign data_o  = valid_o ? mem_r[rd_ptr_r] : {W{1'b0}};
  assign count_o = count_r;

endmodule

// File: rtl/barrett_stream_ctrl.sv
// Streaming controller around barrett_pipelined: holds (m, mu), issues one
// operand per cycle into the reducer and returns results in order through a
// FIFO. Credits (free FIFO slots not yet promised to in-flight operands)
// gate input acceptance so no reducer result is ever dropped.
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o, cfg_m_i, cfg_mu_i   configuration handshake
//   in_valid_i/in_ready_o, in_x_i      operand stream (x < 4m)
//   out_valid_o/out_ready_i, out_r_o   result stream (x mod m)
//   busy_o                              work in flight or buffered
module barrett_stream_ctrl
  import barrett_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = BARRETT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cfg_valid_i,
  output logic         cfg_ready_o,
  input  logic [W-1:0] cfg_m_i,
  input  logic [W-1:0] cfg_mu_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_x_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_r_o,
  output logic         busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  barrett_ctrl_state_e state_r, state_next_s;
  logic [W-1:0]  m_r, mu_r, x_r;
  logic          issue_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] credits_s;
  logic          cfg_ready_s, in_ready_s, cfg_load_s, in_hs_s;
  logic          red_valid_s;
  logic [W-1:0]  red_result_s;

  // Built from registered counts only, so in_ready_o never depends on same-cycle pops.
  assign credits_s = DEPTH_C - fifo_count_s - inflight_r;
  assign in_hs_s   = in_valid_i & in_ready_s;

  // Next-state and handshake readiness.
  always_comb begin
    state_next_s = state_r;
    cfg_ready_s  = 1'b0;
    in_ready_s   = 1'b0;
    cfg_load_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cfg_ready_s = 1'b1;
        if (cfg_valid_i) begin
          cfg_load_s   = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        in_ready_s = (credits_s != {CW{1'b0}});
        if (cfg_valid_i) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        // Modulus may change only once the reducer holds nothing of the old one.
        cfg_ready_s = (inflight_r == {CW{1'b0}});
        if (cfg_valid_i && cfg_ready_s) begin
          cfg_load_s   = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, configuration, issue stage and in-flight counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      m_r        <= {W{1'b0}};
      mu_r       <= {W{1'b0}};
      issue_r    <= 1'b0;
      x_r        <= {W{1'b0}};
      inflight_r <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (cfg_load_s) begin
        m_r  <= cfg_m_i;
        mu_r <= cfg_mu_i;
      end
      issue_r <= in_hs_s;
      if (in_hs_s) begin
        x_r <= in_x_i;
      end
      case ({in_hs_s, red_valid_s})
        2'b10:   inflight_r <= inflight_r + CW'(1'b1);
        2'b01:   inflight_r <= inflight_r - CW'(1'b1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  barrett_pipelined #(
    .W (W)
  ) u_reducer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (issue_r),
    .x_i      (x_r),
    .m_i      (m_r),
    .mu_i     (mu_r),
    .valid_o  (red_valid_s),
    .result_o (red_result_s)
  );

  // Every reducer result is written; credits reserved its slot at issue time.
  barrett_result_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (red_valid_s),
    .data_i  (red_result_s),
    .pop_i   (out_ready_i),
    .valid_o (out_valid_o),
    .data_o  (out_r_o),
    .count_o (fifo_count_s)
  );

  assign cfg_ready_o = cfg_ready_s;
  assign in_ready_o  = in_ready_s;
  assign busy_o      = (inflight_r != {CW{1'b0}}) | (fifo_count_s != {CW{1'b0}});

endmodule

// File: tb/tb_barrett_stream_ctrl.sv
// Directed bench for barrett_stream_ctrl with an in-order scoreboard of
// expected remainders computed by the bench's own % operator.
module tb_barrett_stream_ctrl;
  import barrett_pkg::*;

  localparam int W     = 64;
  localparam int DEPTH = 8;
  localparam int L     = 3;

  localparam logic [W-1:0] M1  = 64'h0000_0000_9215_3525;
  localparam logic [W-1:0] MU1 = 64'h0000_0000_2CDE_B2B0;
  localparam logic [W-1:0] M2  = 64'h0000_0001_2345_6789;
  localparam logic [W-1:0] MU2 = 64'h0000_0000_0E0F_1011;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         cfg_valid_i, cfg_ready_o;
  logic [W-1:0] cfg_m_i, cfg_mu_i;
  logic         in_valid_i, in_ready_o;
  logic [W-1:0] in_x_i;
  logic         out_valid_o, out_ready_i;
  logic [W-1:0] out_r_o;
  logic         busy_o;

  always #5 clk_i = ~clk_i;

  barrett_stream_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_m_i     (cfg_m_i),
    .cfg_mu_i    (cfg_mu_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_x_i      (in_x_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_r_o     (out_r_o),
    .busy_o      (busy_o)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_m = 64'd1;
  int n_vec = 0, n_err = 0, cyc = 0, t_in = -1, t_out = -1, n_pop = 0, acc = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_x();
    logic [W-1:0] r;
    r = {$urandom(), $urandom()};
    return r % (M1 * 64'd4);
  endfunction

  // Mid-cycle: score the handshakes that the coming edge will take, then advance.
  task automatic cycle();
    if (rst_ni) begin
      if (cfg_valid_i && cfg_ready_o) model_m = cfg_m_i;
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(in_x_i % model_m);
        if (t_in < 0) t_in = cyc;
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) chk("spurious_out", {63'd0, out_valid_o}, 64'd0);
        else begin
          chk("result", out_r_o, exp_q.pop_front());
          n_pop++;
        end
      end
    end else begin
      exp_q.delete();
    end
    if (out_valid_o && t_out < 0 && t_in >= 0) t_out = cyc;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) cycle();
    chk(tag, exp_q.size(), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready_o, 64'd1);
    chk({tag, "_in_ready"},  in_ready_o,  64'd0);
    chk({tag, "_out_valid"}, out_valid_o, 64'd0);
    chk({tag, "_out_r"},     out_r_o,     64'd0);
    chk({tag, "_busy"},      busy_o,      64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_m_i = '0; cfg_mu_i = '0;
    in_valid_i = 1'b0; in_x_i = '0; out_ready_i = 1'b0;
    @(negedge clk_i);
    cycle();
    cycle();
    rst_ni = 1'b1;
    chk_reset_outputs("por");

    // Configure and check the IDLE -> RUN handover.
    cfg_valid_i = 1'b1; cfg_m_i = M1; cfg_mu_i = MU1;
    cycle();
    cfg_valid_i = 1'b0;
    chk("cfg_ready_after_cfg", cfg_ready_o, 64'd0);
    chk("in_ready_after_cfg", in_ready_o, 64'd1);
    chk("busy_after_cfg", busy_o, 64'd0);

    // 16 back-to-back operands, free-flowing output.
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid_i = 1'b1; in_x_i = rnd_x();
      chk("in_ready_stream", in_ready_o, 64'd1);
      cycle();
    end
    in_valid_i = 1'b0;
    drain("drain_stream");
    chk("stream_pops", n_pop, 64'd16);
    chk("first_latency", t_out - t_in, L + 2);

    // Sustained backpressure: exactly DEPTH accepts.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int k = 0; k < 40 && in_ready_o; k++) begin
      in_x_i = rnd_x();
      cycle();
      acc++;
    end
    chk("bp_accepts", acc, DEPTH);
    for (int k = 0; k < L + 4; k++) begin
      in_x_i = rnd_x();
      chk("bp_in_ready_low", in_ready_o, 64'd0);
      cycle();
    end
    chk("bp_head_valid", out_valid_o, 64'd1);
    chk("bp_head_hold0", out_r_o, exp_q[0]);
    cycle();
    chk("bp_head_hold1", out_r_o, exp_q[0]);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("bp_release_valid", out_valid_o, 64'd1);
      cycle();
    end
    chk("bp_empty_after", out_valid_o, 64'd0);
    chk("bp_pops", n_pop, 64'd24);

    // Reconfiguration while operands are in flight.
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; in_x_i = rnd_x();
      if (i == 4) begin
        cfg_valid_i = 1'b1; cfg_m_i = M2; cfg_mu_i = MU2;
      end
      chk("rc_in_ready", in_ready_o, 64'd1);
      cycle();
    end
    for (int k = 0; k < 30 && !cfg_ready_o; k++) begin
      in_x_i = rnd_x();
      chk("rc_drain_in_ready", in_ready_o, 64'd0);
      cycle();
    end
    chk("rc_cfg_ready", cfg_ready_o, 64'd1);
    chk("rc_hs_in_ready", in_ready_o, 64'd0);
    cycle();
    cfg_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_x_i = rnd_x();
      chk("rc_new_in_ready", in_ready_o, 64'd1);
      cycle();
    end
    in_valid_i = 1'b0;
    drain("drain_reconfig");
    chk("rc_pops", n_pop, 64'd35);

    // Synchronous reset with results in flight and buffered.
    out_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid_i = 1'b1; in_x_i = rnd_x();
      cycle();
    end
    in_valid_i = 1'b0;
    chk("pre_reset_busy", busy_o, 64'd1);
    rst_ni = 1'b0;
    cycle();
    chk_reset_outputs("midrst");
    rst_ni = 1'b1; out_ready_i = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      chk("post_reset_no_valid", out_valid_o, 64'd0);
      cycle();
    end

    // Full FIFO, then simultaneous push/pop at one result per cycle.
    cfg_valid_i = 1'b1; cfg_m_i = M1; cfg_mu_i = MU1;
    chk("recfg_ready", cfg_ready_o, 64'd1);
    cycle();
    cfg_valid_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int k = 0; k < 20 && in_ready_o; k++) begin
      in_x_i = rnd_x();
      cycle();
    end
    in_valid_i = 1'b0;
    for (int k = 0; k < L + 2; k++) cycle();
    chk("full_depth", exp_q.size(), DEPTH);
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_x_i = rnd_x();
      chk("sustain_valid", out_valid_o, 64'd1);
      cycle();
    end
    in_valid_i = 1'b0;
    drain("drain_sustain");
    chk("final_busy", busy_o, 64'd0);
    chk("final_valid", out_valid_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
